// File: rtl/mips_pkg.sv
// Constants and types shared by the fetch stage and the single-cycle datapath.
package mips_pkg;

   localparam int WORD_W      = 32;
   localparam int INSTR_BYTES = 4;

   typedef logic [WORD_W-1:0] word_t;

   localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;

   // One prefetch queue entry: the fetched word and the byte address it came from.
   typedef struct packed {
      word_t inst;
      word_t pc;
   } fetch_entry_t;

   // Instruction addresses are always word aligned; low two bits are dropped.
   function automatic word_t word_align(input word_t addr);
      return {addr[WORD_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/grant/response bus plus the instruction
// valid/ready hand-off to the datapath, as seen by the fetch unit (master)
// and by its environment (slave).
interface instr_fetch_unit_if;
   import mips_pkg::*;

   logic  mem_req;
   word_t mem_addr;
   logic  mem_gnt;
   logic  mem_rvalid;
   word_t mem_rdata;

   logic  inst_valid;
   word_t inst;
   word_t inst_pc;
   logic  inst_ready;

   modport master (
      output mem_req, mem_addr, inst_valid, inst, inst_pc,
      input  mem_gnt, mem_rvalid, mem_rdata, inst_ready
   );

   modport slave (
      input  mem_req, mem_addr, inst_valid, inst, inst_pc,
      output mem_gnt, mem_rvalid, mem_rdata, inst_ready
   );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous in-order FIFO with flush. Push and pop may coincide at any
// occupancy, including full. The head reads as zero while empty.
module fetch_queue #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   input  logic                   flush,
   output logic [WIDTH-1:0]       head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = empty ? '0 : mem[rd_ptr];

   // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // Storage array write port.
   always_ff @(posedge clk) begin
      // NOTE: the array itself is not reset; count/pointers decide what is valid and head is gated while empty.
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues word reads to a variable-latency
// instruction memory under a credit limit, buffers returned words in order,
// and presents them to the datapath. A redirect flushes buffered words and
// turns every outstanding request into one whose response is discarded.
module instr_fetch_unit
   import mips_pkg::*;
#(
   parameter int    DEPTH    = 4,   // power of two, at least 2
   parameter word_t RESET_PC = DEFAULT_RESET_PC
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      en,
   input  logic                      redirect,
   input  word_t                     redirect_pc,
   instr_fetch_unit_if.master        bus
);

   localparam int CW = $clog2(DEPTH) + 1;

   word_t         fetch_pc;
   logic [CW-1:0] live;        // accepted requests whose responses will be kept
   logic [CW-1:0] drop;        // accepted requests whose responses will be discarded
   logic [CW-1:0] q_count;
   logic [CW-1:0] pc_count;
   logic [CW:0]   credit_used;

   logic grant;
   logic resp_any;
   logic resp_live;
   logic resp_drop;
   logic q_push;
   logic q_pop;
   logic q_full;
   logic q_empty;
   logic pc_full;
   logic pc_empty;

   word_t        pc_head;
   fetch_entry_t q_head;

   // Queue slots are reserved for every request in flight, so a response
   // always has room when it arrives.
   assign credit_used = (CW+1)'(q_count) + (CW+1)'(live) + (CW+1)'(drop);

   assign bus.mem_req  = !reset && en && !redirect && (credit_used < (CW+1)'(DEPTH));
   assign bus.mem_addr = fetch_pc;

   assign grant     = bus.mem_req && bus.mem_gnt;
   assign resp_any  = bus.mem_rvalid && ((live != '0) || (drop != '0));
   assign resp_drop = bus.mem_rvalid && (drop != '0);
   assign resp_live = bus.mem_rvalid && (drop == '0) && (live != '0);

   // A live response arriving together with a redirect belongs to the old stream.
   assign q_push = resp_live && !redirect;
   assign q_pop  = bus.inst_valid && bus.inst_ready;

   assign bus.inst_valid = !q_empty;
   assign bus.inst       = q_head.inst;
   assign bus.inst_pc    = q_head.pc;

   // Fetch PC and outstanding-request accounting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc <= word_align(RESET_PC);
         live     <= '0;
         drop     <= '0;
      end else if (redirect) begin
         // No grant can occur here (mem_req is low); a response this cycle
         // retires one outstanding request, whichever counter it came from.
         fetch_pc <= word_align(redirect_pc);
         live     <= '0;
         drop     <= drop + live - CW'(resp_any);
      end else begin
         if (grant) fetch_pc <= fetch_pc + word_t'(INSTR_BYTES);
         live <= live + CW'(grant) - CW'(resp_live);
         drop <= drop - CW'(resp_drop);
      end
   end

   // Prefetch queue of {instruction, pc} pairs handed to the datapath.
   fetch_queue #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_inst_queue (
      .clk       (clk),
      .reset     (reset),
      .push      (q_push),
      .push_data ({bus.mem_rdata, pc_head}),
      .pop       (q_pop),
      .flush     (redirect),
      .head      (q_head),
      .full      (q_full),
      .empty     (q_empty),
      .count     (q_count)
   );

   // Address of every live request, in issue order, so each kept response
   // is tagged with the pc it was fetched from.
   fetch_queue #(
      .DEPTH (DEPTH),
      .WIDTH (WORD_W)
   ) u_pc_queue (
      .clk       (clk),
      .reset     (reset),
      .push      (grant),
      .push_data (fetch_pc),
      .pop       (resp_live),
      .flush     (redirect),
      .head      (pc_head),
      .full      (pc_full),
      .empty     (pc_empty),
      .count     (pc_count)
   );

   // Protocol and internal consistency properties.
   a_no_orphan_resp : assert property (@(posedge clk) disable iff (reset)
      bus.mem_rvalid |-> ((live != '0) || (drop != '0)));
   a_pc_tracks_live : assert property (@(posedge clk) disable iff (reset)
      pc_count == live);
   a_pc_room : assert property (@(posedge clk) disable iff (reset)
      grant |-> !pc_full);
   a_pc_present : assert property (@(posedge clk) disable iff (reset)
      resp_live |-> !pc_empty);
   a_queue_room : assert property (@(posedge clk) disable iff (reset)
      q_push |-> (!q_full || q_pop));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a fixed-latency, in-order
// instruction memory model. Memory word at address A reads as A + 0x1000_0000.
module tb_instr_fetch_unit;

   logic        clk;
   logic        reset;
   logic        en;
   logic        redirect;
   logic [31:0] redirect_pc;

   int errors = 0;
   int checks = 0;

   int mem_lat = 1;
   int cyc = 0;
   int gnt_count = 0;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   pend_t pend[$];

   instr_fetch_unit_if bus_if ();

   instr_fetch_unit #(
      .DEPTH    (4),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .bus         (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] dat(input logic [31:0] a);
      return a + 32'h1000_0000;
   endfunction

   // Memory model: grant recorded at the edge, response driven just after
   // the edge so that it is sampled mem_lat edges after its grant.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         pend.delete();
         bus_if.mem_rvalid = 1'b0;
         bus_if.mem_rdata  = '0;
         cyc               = 0;
         gnt_count         = 0;
      end else begin
         cyc++;
         if (bus_if.mem_rvalid) void'(pend.pop_front());
         if (bus_if.mem_req && bus_if.mem_gnt) begin
            pend.push_back('{addr: bus_if.mem_addr, due: cyc + mem_lat});
            gnt_count++;
         end
         #1;
         if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
            bus_if.mem_rvalid = 1'b1;
            bus_if.mem_rdata  = dat(pend[0].addr);
         end else begin
            bus_if.mem_rvalid = 1'b0;
            bus_if.mem_rdata  = '0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   // Hold reset for two cycles; returns at the negedge where reset drops.
   task automatic do_reset(input int lat);
      @(negedge clk);
      reset = 1'b1;
      en = 1'b0;
      redirect = 1'b0;
      redirect_pc = '0;
      bus_if.mem_gnt = 1'b1;
      bus_if.inst_ready = 1'b0;
      mem_lat = lat;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      en = 1'b1;
      redirect = 1'b0;
      redirect_pc = '0;
      bus_if.mem_gnt = 1'b1;
      bus_if.inst_ready = 1'b1;
      mem_lat = 1;
      #1;
      checks++; if (bus_if.inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b expected 0", bus_if.inst_valid); end
      checks++; if (bus_if.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", bus_if.mem_req); end
      checks++; if (bus_if.inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 0", bus_if.inst); end
      checks++; if (bus_if.inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc: got %h expected 0", bus_if.inst_pc); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      en = 1'b0;
      #1;
      checks++; if (bus_if.mem_req !== 1'b0) begin errors++; $display("FAIL en_low_mem_req: got %b expected 0", bus_if.mem_req); end
      @(negedge clk);
      en = 1'b1;
      #1;
      checks++; if (bus_if.mem_req !== 1'b1) begin errors++; $display("FAIL first_mem_req: got %b expected 1", bus_if.mem_req); end
      checks++; if (bus_if.mem_addr !== 32'h0) begin errors++; $display("FAIL first_mem_addr: got %h expected 0", bus_if.mem_addr); end
   endtask

   task automatic test_stream();
      logic [31:0] exp_addr;
      logic [31:0] exp_pc;
      do_reset(1);
      en = 1'b1;
      bus_if.inst_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         exp_addr = 32'(4 * i);
         checks++; if (bus_if.mem_req !== 1'b1 || bus_if.mem_addr !== exp_addr) begin errors++; $display("FAIL stream_addr[%0d]: got req=%b addr=%h expected req=1 addr=%h", i, bus_if.mem_req, bus_if.mem_addr, exp_addr); end
         if (i >= 2) begin
            exp_pc = 32'(4 * (i - 2));
            checks++; if (bus_if.inst_valid !== 1'b1 || bus_if.inst_pc !== exp_pc || bus_if.inst !== dat(exp_pc)) begin errors++; $display("FAIL stream_inst[%0d]: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h", i, bus_if.inst_valid, bus_if.inst_pc, bus_if.inst, exp_pc, dat(exp_pc)); end
         end else begin
            checks++; if (bus_if.inst_valid !== 1'b0) begin errors++; $display("FAIL stream_early_valid[%0d]: got %b expected 0", i, bus_if.inst_valid); end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_pc;
      do_reset(1);
      en = 1'b1;
      bus_if.inst_ready = 1'b0;
      repeat (8) @(negedge clk);
      #1;
      checks++; if (bus_if.mem_req !== 1'b0) begin errors++; $display("FAIL bp_mem_req: got %b expected 0", bus_if.mem_req); end
      checks++; if (gnt_count !== 4) begin errors++; $display("FAIL bp_grants: got %0d expected 4", gnt_count); end
      checks++; if (bus_if.inst_valid !== 1'b1 || bus_if.inst_pc !== 32'h0) begin errors++; $display("FAIL bp_head: got v=%b pc=%h expected v=1 pc=0", bus_if.inst_valid, bus_if.inst_pc); end
      bus_if.inst_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) begin
            @(negedge clk);
            #1;
         end
         exp_pc = 32'(4 * k);
         checks++; if (bus_if.inst_valid !== 1'b1 || bus_if.inst_pc !== exp_pc || bus_if.inst !== dat(exp_pc)) begin errors++; $display("FAIL bp_drain[%0d]: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h", k, bus_if.inst_valid, bus_if.inst_pc, bus_if.inst, exp_pc, dat(exp_pc)); end
      end
   endtask

   task automatic test_redirect_latency();
      bit found;
      do_reset(3);
      en = 1'b1;
      bus_if.inst_ready = 1'b1;
      repeat (2) @(negedge clk);
      redirect = 1'b1;
      redirect_pc = 32'h0000_0103;
      #1;
      checks++; if (bus_if.mem_req !== 1'b0) begin errors++; $display("FAIL redir_req_low: got %b expected 0", bus_if.mem_req); end
      @(negedge clk);
      redirect = 1'b0;
      #1;
      checks++; if (bus_if.mem_req !== 1'b1 || bus_if.mem_addr !== 32'h0000_0100) begin errors++; $display("FAIL redir_new_addr: got req=%b addr=%h expected req=1 addr=00000100", bus_if.mem_req, bus_if.mem_addr); end
      found = 1'b0;
      for (int n = 0; n < 10 && !found; n++) begin
         @(negedge clk);
         #1;
         if (bus_if.inst_valid === 1'b1) found = 1'b1;
      end
      checks++; if (!found || bus_if.inst_pc !== 32'h0000_0100 || bus_if.inst !== dat(32'h0000_0100)) begin errors++; $display("FAIL redir_first_inst: got found=%b pc=%h inst=%h expected pc=00000100 inst=%h", found, bus_if.inst_pc, bus_if.inst, dat(32'h0000_0100)); end
      @(negedge clk);
      #1;
      checks++; if (bus_if.inst_valid !== 1'b1 || bus_if.inst_pc !== 32'h0000_0104) begin errors++; $display("FAIL redir_second_inst: got v=%b pc=%h expected v=1 pc=00000104", bus_if.inst_valid, bus_if.inst_pc); end
   endtask

   task automatic test_redirect_collide();
      do_reset(1);
      en = 1'b1;
      bus_if.inst_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (bus_if.inst_valid !== 1'b1 || bus_if.inst_pc !== 32'h4) begin errors++; $display("FAIL coll_pre_head: got v=%b pc=%h expected v=1 pc=4", bus_if.inst_valid, bus_if.inst_pc); end
      redirect = 1'b1;
      redirect_pc = 32'h0000_0202;
      @(negedge clk);
      redirect = 1'b0;
      #1;
      checks++; if (bus_if.inst_valid !== 1'b0) begin errors++; $display("FAIL coll_flushed: got %b expected 0", bus_if.inst_valid); end
      checks++; if (bus_if.mem_req !== 1'b1 || bus_if.mem_addr !== 32'h0000_0200) begin errors++; $display("FAIL coll_new_addr: got req=%b addr=%h expected req=1 addr=00000200", bus_if.mem_req, bus_if.mem_addr); end
      @(negedge clk);
      #1;
      checks++; if (bus_if.inst_valid !== 1'b0) begin errors++; $display("FAIL coll_still_empty: got %b expected 0", bus_if.inst_valid); end
      @(negedge clk);
      #1;
      checks++; if (bus_if.inst_valid !== 1'b1 || bus_if.inst_pc !== 32'h0000_0200 || bus_if.inst !== dat(32'h0000_0200)) begin errors++; $display("FAIL coll_first_inst: got v=%b pc=%h inst=%h expected v=1 pc=00000200 inst=%h", bus_if.inst_valid, bus_if.inst_pc, bus_if.inst, dat(32'h0000_0200)); end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_addr;
      logic [31:0] exp_pc;
      do_reset(1);
      en = 1'b1;
      bus_if.inst_ready = 1'b1;
      redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      #1;
      checks++; if (bus_if.mem_req !== 1'b0) begin errors++; $display("FAIL wrap_redir_req: got %b expected 0", bus_if.mem_req); end
      exp_addr = 32'hFFFF_FFF8;
      exp_pc   = 32'hFFFF_FFF8;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         redirect = 1'b0;
         #1;
         checks++; if (bus_if.mem_req !== 1'b1 || bus_if.mem_addr !== exp_addr) begin errors++; $display("FAIL wrap_addr[%0d]: got req=%b addr=%h expected req=1 addr=%h", i, bus_if.mem_req, bus_if.mem_addr, exp_addr); end
         exp_addr = exp_addr + 32'd4;
         if (i >= 3) begin
            checks++; if (bus_if.inst_valid !== 1'b1 || bus_if.inst_pc !== exp_pc || bus_if.inst !== dat(exp_pc)) begin errors++; $display("FAIL wrap_inst[%0d]: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h", i, bus_if.inst_valid, bus_if.inst_pc, bus_if.inst, exp_pc, dat(exp_pc)); end
            exp_pc = exp_pc + 32'd4;
         end
      end
   endtask

   task automatic test_reset_midop();
      bit found;
      do_reset(2);
      en = 1'b1;
      bus_if.inst_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (bus_if.inst_valid !== 1'b1 || bus_if.mem_req !== 1'b1) begin errors++; $display("FAIL mid_pre_state: got v=%b req=%b expected v=1 req=1", bus_if.inst_valid, bus_if.mem_req); end
      #2;
      reset = 1'b1;
      #1;
      checks++; if (bus_if.inst_valid !== 1'b0 || bus_if.mem_req !== 1'b0) begin errors++; $display("FAIL mid_async_clear: got v=%b req=%b expected v=0 req=0", bus_if.inst_valid, bus_if.mem_req); end
      checks++; if (bus_if.inst !== 32'h0 || bus_if.inst_pc !== 32'h0) begin errors++; $display("FAIL mid_outputs_zero: got inst=%h pc=%h expected 0 0", bus_if.inst, bus_if.inst_pc); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      bus_if.inst_ready = 1'b1;
      #1;
      checks++; if (bus_if.mem_req !== 1'b1 || bus_if.mem_addr !== 32'h0) begin errors++; $display("FAIL mid_restart_addr: got req=%b addr=%h expected req=1 addr=0", bus_if.mem_req, bus_if.mem_addr); end
      checks++; if (bus_if.inst_valid !== 1'b0) begin errors++; $display("FAIL mid_restart_empty: got %b expected 0", bus_if.inst_valid); end
      found = 1'b0;
      for (int n = 0; n < 8 && !found; n++) begin
         @(negedge clk);
         #1;
         if (bus_if.inst_valid === 1'b1) found = 1'b1;
      end
      checks++; if (!found || bus_if.inst_pc !== 32'h0 || bus_if.inst !== dat(32'h0)) begin errors++; $display("FAIL mid_restart_inst: got found=%b pc=%h inst=%h expected pc=0 inst=%h", found, bus_if.inst_pc, bus_if.inst, dat(32'h0)); end
   endtask

   initial begin
      reset = 1'b1;
      en = 1'b0;
      redirect = 1'b0;
      redirect_pc = '0;
      bus_if.mem_gnt = 1'b1;
      bus_if.inst_ready = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_latency();
      test_redirect_collide();
      test_wrap();
      test_reset_midop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
